// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O block for a small MCU.
//   Write map: 0x40 LEDS, 0x81 SSEG, 0x50 TMR_LO, 0x51 TMR_HI,
//              0x52 TMR_CTRL (bit0 run, bit1 timer int enable),
//              0x53 INT_ACK (write-1-to-clear PEND), 0x54 INT_MASK[1:0].
//   Read map:  0x20 SWITCHES (synchronized), 0x24 BTN_STATE, 0x30 PEND,
//              0x54 INT_MASK, 0x52 TMR_CTRL; anything else reads 0x00.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   OUT_PORT, PORT_ID     MCU write data and port address
//   IO_STRB               one-cycle write strobe
//   IN_PORT               combinational read data
//   INTERRUPT             registered |(PEND & INT_MASK)
//   SWITCHES, BUTTONS     asynchronous board inputs
//   LEDS, SSEG            registered board outputs (SSEG active-low)
// Build option: define IO_RESPONDER_DEBOUNCE_EN to debounce the buttons for
// DB_CYCLES stable cycles; otherwise BTN_STATE is the synchronizer output.
module io_responder #(
    parameter logic [15:0] DB_CYCLES = 16'd1000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] OUT_PORT,
    input  logic [7:0] PORT_ID,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       INTERRUPT,
    input  logic [7:0] SWITCHES,
    input  logic [3:0] BUTTONS,
    output logic [7:0] LEDS,
    output logic [7:0] SSEG
);

    logic [7:0]  sw_s1_q, sw_s2_q;
    logic [3:0]  btn_s1_q, btn_s2_q, btn_prev_q;
    logic [3:0]  btn_state;
    logic [7:0]  leds_q, sseg_q, tmr_lo_q, tmr_hi_q;
    logic [1:0]  ctrl_q, mask_q, pend_q, pend_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] rld;
    logic        irq_q;
    logic        tmr_start, tmr_evt;
    logic [1:0]  pend_set, pend_clr;
    logic [3:0]  btn_rise;

`ifdef IO_RESPONDER_DEBOUNCE_EN
    logic [3:0]       btn_state_q;
    logic [3:0][15:0] db_cnt_q;

    // A button's state follows the synchronizer only after the new level has
    // been seen for DB_CYCLES consecutive cycles; any return resets the count.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (RESET) begin
                btn_state_q[i] <= 1'b0;
                db_cnt_q[i]    <= '0;
            end else if (btn_s2_q[i] == btn_state_q[i]) begin
                db_cnt_q[i]    <= '0;
            end else if (db_cnt_q[i] >= DB_CYCLES - 16'd1) begin
                btn_state_q[i] <= btn_s2_q[i];
                db_cnt_q[i]    <= '0;
            end else begin
                db_cnt_q[i]    <= db_cnt_q[i] + 16'd1;
            end
        end
    end

    assign btn_state = btn_state_q;
`else
    logic unused_db_cycles;
    assign unused_db_cycles = ^DB_CYCLES;
    assign btn_state        = btn_s2_q;
`endif

    assign rld       = {tmr_hi_q, tmr_lo_q};
    assign btn_rise  = btn_state & ~btn_prev_q;
    assign tmr_start = IO_STRB && (PORT_ID == 8'h52) && OUT_PORT[0] && !ctrl_q[0];

    // Timer and pending-interrupt next state.
    always_comb begin
        tcnt_d  = tcnt_q;
        tmr_evt = 1'b0;
        if (tmr_start) begin
            tcnt_d = rld;
        end else if (ctrl_q[0] && (rld != 16'd0)) begin
            if (tcnt_q == 16'd0) begin
                tcnt_d  = rld;
                tmr_evt = 1'b1;
            end else begin
                tcnt_d = tcnt_q - 16'd1;
            end
        end
        pend_set = {|btn_rise, tmr_evt & ctrl_q[1]};
        pend_clr = (IO_STRB && (PORT_ID == 8'h53)) ? OUT_PORT[1:0] : 2'b00;
        // Set is applied after clear so a coincident event wins.
        pend_d   = (pend_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
            leds_q     <= '0;
            sseg_q     <= 8'hFF;
            tmr_lo_q   <= '0;
            tmr_hi_q   <= '0;
            ctrl_q     <= '0;
            mask_q     <= '0;
            pend_q     <= '0;
            tcnt_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            sw_s1_q    <= SWITCHES;
            sw_s2_q    <= sw_s1_q;
            btn_s1_q   <= BUTTONS;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_state;
            pend_q     <= pend_d;
            tcnt_q     <= tcnt_d;
            irq_q      <= |(pend_q & mask_q);
            if (IO_STRB) begin
                case (PORT_ID)
                    8'h40:   leds_q   <= OUT_PORT;
                    8'h81:   sseg_q   <= OUT_PORT;
                    8'h50:   tmr_lo_q <= OUT_PORT;
                    8'h51:   tmr_hi_q <= OUT_PORT;
                    8'h52:   ctrl_q   <= OUT_PORT[1:0];
                    8'h54:   mask_q   <= OUT_PORT[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        IN_PORT = 8'h00;
        case (PORT_ID)
            8'h20:   IN_PORT = sw_s2_q;
            8'h24:   IN_PORT = {4'b0000, btn_state};
            8'h30:   IN_PORT = {6'b000000, pend_q};
            8'h54:   IN_PORT = {6'b000000, mask_q};
            8'h52:   IN_PORT = {6'b000000, ctrl_q};
            default: IN_PORT = 8'h00;
        endcase
    end

    assign INTERRUPT = irq_q;
    assign LEDS      = leds_q;
    assign SSEG      = sseg_q;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed literal checks followed by
// randomized traffic compared every cycle against a behavioural model.
module tb_io_responder;

    localparam logic [15:0] DB = 16'd4;

    logic       CLK;
    logic       RESET;
    logic [7:0] OUT_PORT;
    logic [7:0] PORT_ID;
    logic       IO_STRB;
    logic [7:0] IN_PORT;
    logic       INTERRUPT;
    logic [7:0] SWITCHES;
    logic [3:0] BUTTONS;
    logic [7:0] LEDS;
    logic [7:0] SSEG;

    int checks = 0;
    int errors = 0;

    io_responder #(.DB_CYCLES(DB)) dut (
        .CLK(CLK), .RESET(RESET), .OUT_PORT(OUT_PORT), .PORT_ID(PORT_ID),
        .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .INTERRUPT(INTERRUPT),
        .SWITCHES(SWITCHES), .BUTTONS(BUTTONS), .LEDS(LEDS), .SSEG(SSEG)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model state: the timer is tracked as cycles elapsed in the current
    // period rather than a down-counter; inputs are kept as sample histories.
    typedef struct packed {
        logic             valid;
        logic [7:0]       leds;
        logic [7:0]       sseg;
        logic [15:0]      rld;
        logic             run;
        logic             ie;
        logic [15:0]      period;
        logic [15:0]      elapsed;
        logic [1:0]       pend;
        logic [1:0]       mask;
        logic             irq;
        logic [7:0]       sh0;
        logic [7:0]       sh1;
        logic [3:0]       bh0;
        logic [3:0]       bh1;
        logic [3:0]       bprev;
        logic [3:0]       mb;
        logic [3:0][15:0] mc;
    } mstate_t;

    mstate_t m = '0;

    function automatic logic [3:0] btn_of(mstate_t s);
`ifdef IO_RESPONDER_DEBOUNCE_EN
        return s.mb;
`else
        return s.bh1;
`endif
    endfunction

    function automatic mstate_t step(mstate_t s, logic rst, logic strb, logic [7:0] id,
                                     logic [7:0] d, logic [7:0] sw, logic [3:0] bt);
        mstate_t    n;
        logic       evt;
        logic [3:0] cur;
        logic [1:0] clr;
        n = s;
        if (rst) begin
            n       = '0;
            n.sseg  = 8'hFF;
            n.valid = 1'b1;
            return n;
        end
        evt   = 1'b0;
        n.irq = |(s.pend & s.mask);
        if (strb && id == 8'h52 && d[0] && !s.run) begin
            n.period  = s.rld;
            n.elapsed = 16'd0;
        end else if (s.run && s.rld != 16'd0) begin
            if (s.elapsed >= s.period) begin
                evt       = 1'b1;
                n.elapsed = 16'd0;
                n.period  = s.rld;
            end else begin
                n.elapsed = s.elapsed + 16'd1;
            end
        end
        cur     = btn_of(s);
        n.bprev = cur;
        clr     = (strb && id == 8'h53) ? d[1:0] : 2'b00;
        n.pend  = (s.pend & ~clr) | {|(cur & ~s.bprev), evt & s.ie};
        if (strb) begin
            case (id)
                8'h40: n.leds = d;
                8'h81: n.sseg = d;
                8'h50: n.rld[7:0] = d;
                8'h51: n.rld[15:8] = d;
                8'h52: {n.ie, n.run} = d[1:0];
                8'h54: n.mask = d[1:0];
                default: ;
            endcase
        end
        n.sh1 = s.sh0;
        n.sh0 = sw;
        n.bh1 = s.bh0;
        n.bh0 = bt;
        for (int i = 0; i < 4; i++) begin
            if (s.bh1[i] == s.mb[i]) begin
                n.mc[i] = 16'd0;
            end else if (s.mc[i] + 16'd1 >= DB) begin
                n.mb[i] = s.bh1[i];
                n.mc[i] = 16'd0;
            end else begin
                n.mc[i] = s.mc[i] + 16'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] read_of(mstate_t s, logic [7:0] id);
        case (id)
            8'h20:   return s.sh1;
            8'h24:   return {4'b0000, btn_of(s)};
            8'h30:   return {6'b000000, s.pend};
            8'h54:   return {6'b000000, s.mask};
            8'h52:   return {6'b000000, s.ie, s.run};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge CLK) begin
        m <= step(m, RESET, IO_STRB, PORT_ID, OUT_PORT, SWITCHES, BUTTONS);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m.valid) begin
            chk("model_leds", LEDS, m.leds);
            chk("model_sseg", SSEG, m.sseg);
            chk("model_irq", {7'b0, INTERRUPT}, {7'b0, m.irq});
            chk("model_in_port", IN_PORT, read_of(m, PORT_ID));
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] id, input logic [7:0] exp);
        PORT_ID = id;
        #1;
        chk(nm, IN_PORT, exp);
    endtask

    logic [7:0] ids [10] = '{8'h40, 8'h81, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h41,
                             8'h20, 8'h30};
    logic [7:0] rids [7] = '{8'h20, 8'h24, 8'h30, 8'h54, 8'h52, 8'h99, 8'h00};

    initial begin
        RESET = 1'b1; OUT_PORT = '0; PORT_ID = '0; IO_STRB = 1'b0;
        SWITCHES = '0; BUTTONS = '0;
        repeat (3) tick();
        RESET = 1'b0;

        chk("rst_leds", LEDS, 8'h00);
        chk("rst_sseg", SSEG, 8'hFF);
        chk("rst_irq", {7'b0, INTERRUPT}, 8'h00);
        rd_chk("rst_pend", 8'h30, 8'h00);

        wr(8'h40, 8'hA5);
        chk("leds_write", LEDS, 8'hA5);
        wr(8'h41, 8'h5A);
        chk("unmapped_leds", LEDS, 8'hA5);
        chk("unmapped_sseg", SSEG, 8'hFF);
        rd_chk("unmapped_mask", 8'h54, 8'h00);
        wr(8'h81, 8'h3C);
        chk("sseg_write", SSEG, 8'h3C);

        SWITCHES = 8'h3C;
        PORT_ID  = 8'h20;
        tick(); tick();
        chk("switch_sync", IN_PORT, 8'h3C);
        rd_chk("read_unmapped", 8'h99, 8'h00);

        // Reload 3: period of four cycles after the start write.
        wr(8'h50, 8'h03);
        wr(8'h51, 8'h00);
        wr(8'h54, 8'h01);
        wr(8'h52, 8'h03);
        PORT_ID = 8'h30;
        tick(); tick(); tick();
        chk("tmr_no_evt_yet", IN_PORT, 8'h00);
        tick();
        chk("tmr_first_evt", IN_PORT, 8'h01);
        chk("irq_lag", {7'b0, INTERRUPT}, 8'h00);
        tick();
        chk("irq_rise", {7'b0, INTERRUPT}, 8'h01);
        wr(8'h53, 8'h01);
        rd_chk("ack_clears", 8'h30, 8'h00);
        chk("irq_held", {7'b0, INTERRUPT}, 8'h01);
        tick();
        chk("irq_fall", {7'b0, INTERRUPT}, 8'h00);
        wr(8'h53, 8'h01);
        rd_chk("ack_vs_evt", 8'h30, 8'h01);
        tick();
        chk("irq_again", {7'b0, INTERRUPT}, 8'h01);

        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("mid_rst_leds", LEDS, 8'h00);
        chk("mid_rst_sseg", SSEG, 8'hFF);
        chk("mid_rst_irq", {7'b0, INTERRUPT}, 8'h00);
        rd_chk("mid_rst_ctrl", 8'h52, 8'h00);
        PORT_ID = 8'h30;
        repeat (12) tick();
        chk("timer_stopped", IN_PORT, 8'h00);

`ifndef IO_RESPONDER_DEBOUNCE_EN
        BUTTONS = 4'b0100;
        tick(); tick();
        chk("btn_early", IN_PORT, 8'h00);
        tick();
        chk("btn_pend", IN_PORT, 8'h02);
`endif

        for (int i = 0; i < 3000; i++) begin
            RESET   = ($urandom_range(0, 149) == 0);
            IO_STRB = ($urandom_range(0, 2) == 0);
            if (IO_STRB) begin
                PORT_ID  = ids[$urandom_range(0, 9)];
                OUT_PORT = 8'($urandom);
                if (PORT_ID == 8'h50) OUT_PORT = 8'($urandom_range(0, 7));
                if (PORT_ID == 8'h51) OUT_PORT = ($urandom_range(0, 15) == 0) ? 8'h01 : 8'h00;
            end else begin
                PORT_ID = rids[$urandom_range(0, 6)];
            end
            if ($urandom_range(0, 7) == 0) SWITCHES = 8'($urandom);
            if ($urandom_range(0, 5) == 0) BUTTONS = BUTTONS ^ 4'($urandom);
            tick();
        end
        RESET = 1'b0;
        IO_STRB = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
